jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
- Upstream stage for the JK flip-flop. Accepts queued commands (hold/reset/set/toggle plus repeat count) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the flip-flop's j/k inputs, one command per run of cycles.
- Lets control logic script q sequences without cycle-exact timing on its side.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CNT_W, 4, repeat-count width; a command drives its op for cnt+1 issued cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full && !rst.
- cmd_op  in  2  {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
- cmd_cnt  in  CNT_W  repeat count minus one.
- run  in  1  issue enable; low pauses issuing.
- j  out  1  to flip-flop j.
- k  out  1  to flip-flop k.
- busy  out  1  state==ISSUE or FIFO non-empty.
- done  out  1  one-cycle pulse when the queue drains to IDLE.
- fifo_level  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high, the next edge clears the FIFO (level 0), state=IDLE, op_reg=00, rem=0, done=0. cmd_ready=0 during rst. Reset mid-ISSUE abandons the current and queued commands.
- Push: on an edge with cmd_valid && cmd_ready, {cmd_op,cmd_cnt} is written. No write when full. No bypass: an empty-FIFO push issues no earlier than the next edge.
- Outputs: {j,k} = (state==ISSUE && run) ? op_reg : 00. These are combinational from registers and run only; no input-to-output path from cmd_*.
- IDLE: edge with run && !empty pops the head, op_reg<=op, rem<=cnt, state<=ISSUE.
- ISSUE, edge with run=1: that cycle counts as issued.
  - If rem!=0: rem<=rem-1.
  - Else if !empty: pop the next command back-to-back (no bubble).
  - Else: state<=IDLE, done<=1 for one cycle.
- ISSUE, edge with run=0: nothing changes; j,k=00 (flip-flop holds).
- Latency: push at edge N into an empty, idle FIFO with run high gives j,k valid after edge N+1. The flip-flop samples at edge N+2.
- Simultaneous push and pop: both occur; level unchanged. Full FIFO with pop gives cmd_ready=0 that cycle anyway (registered full).
- Pointers wrap modulo DEPTH. Level counts 0..DEPTH.

Optional Feature:
- JKSEQ_SHADOW_EN defined: adds input q_fb (1, the flip-flop q), output q_shadow (1), and output mismatch (1).
  - q_shadow is reset to 0 by rst and updates each edge from the current j,k per the JK table.
  - mismatch is sticky; it sets on any cycle with q_fb!=q_shadow and is cleared only by rst.
  - The flip-flop must be reset together with this block.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package jkseq_pkg:
  - OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TGL=2'b11.
  - State encoding IDLE/ISSUE.
  - Command entry width 2+CNT_W.
- Sub-module jkseq_fifo: synchronous FIFO (DEPTH, WIDTH), with push/pop/full/empty/level. The sequencer FSM and output gating stay in the top.

Test Plan:
- Reset then push SET cnt=0, run=1: j,k=10 for exactly 1 cycle starting after push edge+1; then 00; done pulses once; busy falls.
- Push TGL cnt=3, then SET cnt=1, run=1: j,k = 11,11,11,11,10,10 contiguous; done pulses once, after the last.
- Fill 4 commands with run=0: cmd_ready=0, fifo_level=4, 5th push dropped. Raise run: all 4 issue in order.
- TGL cnt=2 with run low on the 2nd issued cycle: j,k=11,00,11,11. Total issued toggles=3.
- Assert rst mid-ISSUE with 2 queued: after the edge, j,k=00, fifo_level=0, state IDLE, no done pulse.
- With JKSEQ_SHADOW_EN, drive q_fb from the flip-flop through SET, TGL cnt=1, RST: mismatch stays 0. Force q_fb inverted one cycle: mismatch=1 until rst.

Source files
------------

// File: rtl/jkseq_pkg.sv
// jkseq_pkg: shared op codes, FSM states and command-entry width for the JK command sequencer.
package jkseq_pkg;
   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;
   localparam int OP_W = 2;
   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
   function automatic int entry_w(input int cnt_w);
      return OP_W + cnt_w;
   endfunction
endpackage

// File: rtl/jkseq_fifo.sv
// jkseq_fifo: synchronous FIFO with registered level; pushes when full and pops when empty are ignored.
module jkseq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] lvl_q, lvl_d;
   logic do_push, do_pop;
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      lvl_d   = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end
   assign rdata = mem_q[rd_q];
   assign full  = lvl_q == (AW+1)'(DEPTH);
   assign empty = lvl_q == '0;
   assign level = lvl_q;
endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {op,cnt} commands and drives JK j/k for cnt+1 issued cycles each.
// Define JKSEQ_SHADOW_EN to add the q_fb/q_shadow/mismatch flip-flop shadow checker.
module jk_cmd_sequencer
   import jkseq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [CNT_W-1:0]         cmd_cnt,
   input  logic                     run,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   fifo_level
`ifdef JKSEQ_SHADOW_EN
   ,
   input  logic                     q_fb,
   output logic                     q_shadow,
   output logic                     mismatch
`endif
);
   localparam int EW = entry_w(CNT_W);
   state_t state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic done_q, done_d;
   logic full, empty, push, load, last;
   logic [EW-1:0] head;
   jkseq_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (load),
      .wdata ({cmd_op, cmd_cnt}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_HOLD;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end
   // Final issued cycle of a command either loads the next head back-to-back or drains to IDLE.
   always_comb begin
      last    = run && state_q == ISSUE && rem_q == '0;
      load    = run && !empty && (state_q == IDLE || rem_q == '0);
      done_d  = last && empty;
      state_d = load ? ISSUE : done_d ? IDLE : state_q;
      op_d    = load ? head[EW-1 -: OP_W] : op_q;
      rem_d   = load ? head[CNT_W-1:0] : (run && state_q == ISSUE && rem_q != '0) ? rem_q - 1'b1 : rem_q;
   end
   always_comb begin
      cmd_ready = !full && !rst;
      push      = cmd_valid && cmd_ready;
      {j, k}    = (state_q == ISSUE && run) ? op_q : OP_HOLD;
      busy      = state_q == ISSUE || !empty;
      done      = done_q;
   end
`ifdef JKSEQ_SHADOW_EN
   logic q_shadow_q, q_shadow_d, mismatch_q, mismatch_d;
   always_comb begin
      q_shadow_d = (j && k) ? !q_shadow_q : j ? 1'b1 : k ? 1'b0 : q_shadow_q;
      mismatch_d = mismatch_q || (q_fb != q_shadow_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         q_shadow_q <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         q_shadow_q <= q_shadow_d;
         mismatch_q <= mismatch_d;
      end
   end
   assign q_shadow = q_shadow_q;
   assign mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed self-checking bench for jk_cmd_sequencer (shadow checks when JKSEQ_SHADOW_EN).
module tb_jk_cmd_sequencer;
   logic clk = 1'b0;
   logic rst, cmd_valid, cmd_ready, run, j, k, busy, done;
   logic [1:0] cmd_op;
   logic [3:0] cmd_cnt;
   logic [2:0] fifo_level;
   int checks = 0;
   int errors = 0;
   int toggles;
   logic [1:0] exp3 [5];
   always #5 clk = ~clk;
`ifdef JKSEQ_SHADOW_EN
   logic q_fb, q_shadow, mismatch, q_ff, inv;
   always_ff @(posedge clk) begin
      if (rst) q_ff <= 1'b0;
      else q_ff <= (j && k) ? !q_ff : j ? 1'b1 : k ? 1'b0 : q_ff;
   end
   assign q_fb = q_ff ^ inv;
`endif
   jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_cnt    (cmd_cnt),
      .run        (run),
      .j          (j),
      .k          (k),
      .busy       (busy),
      .done       (done),
      .fifo_level (fifo_level)
`ifdef JKSEQ_SHADOW_EN
      ,
      .q_fb       (q_fb),
      .q_shadow   (q_shadow),
      .mismatch   (mismatch)
`endif
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [1:0] op, input logic [3:0] cnt);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_cnt = cnt;
      tick();
      cmd_valid = 1'b0;
   endtask
   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 4'd0; run = 1'b0;
`ifdef JKSEQ_SHADOW_EN
      inv = 1'b0;
`endif
      tick(); tick();
      check("rst_jk", {30'd0, j, k}, 32'd0);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
      // single SET cnt=0
      run = 1'b1;
      push(2'b10, 4'd0);
      check("t1_push_jk", {30'd0, j, k}, 32'd0);
      check("t1_push_level", {29'd0, fifo_level}, 32'd1);
      check("t1_push_busy", {31'd0, busy}, 32'd1);
      tick();
      check("t1_issue_jk", {30'd0, j, k}, 32'd2);
      check("t1_issue_level", {29'd0, fifo_level}, 32'd0);
      check("t1_issue_done", {31'd0, done}, 32'd0);
      tick();
      check("t1_end_jk", {30'd0, j, k}, 32'd0);
      check("t1_end_done", {31'd0, done}, 32'd1);
      check("t1_end_busy", {31'd0, busy}, 32'd0);
      tick();
      check("t1_done_once", {31'd0, done}, 32'd0);
      // TGL cnt=3 then SET cnt=1 back-to-back
      push(2'b11, 4'd3);
      push(2'b10, 4'd1);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t2_jk%0d", i), {30'd0, j, k}, (i < 4) ? 32'd3 : 32'd2);
         check($sformatf("t2_done%0d", i), {31'd0, done}, 32'd0);
         tick();
      end
      check("t2_end_jk", {30'd0, j, k}, 32'd0);
      check("t2_end_done", {31'd0, done}, 32'd1);
      tick();
      check("t2_done_once", {31'd0, done}, 32'd0);
      // fill with run low, drop fifth push, then drain in order
      run = 1'b0;
      push(2'b10, 4'd0);
      push(2'b01, 4'd0);
      push(2'b11, 4'd1);
      push(2'b10, 4'd0);
      check("t3_full_level", {29'd0, fifo_level}, 32'd4);
      check("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
      check("t3_paused_jk", {30'd0, j, k}, 32'd0);
      push(2'b01, 4'd5);
      check("t3_drop_level", {29'd0, fifo_level}, 32'd4);
      exp3 = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10};
      run = 1'b1;
      tick();
      check("t3_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_jk%0d", i), {30'd0, j, k}, {30'd0, exp3[i]});
         tick();
      end
      check("t3_end_done", {31'd0, done}, 32'd1);
      check("t3_end_level", {29'd0, fifo_level}, 32'd0);
      // TGL cnt=2 with run low on the second cycle
      toggles = 0;
      push(2'b11, 4'd2);
      tick();
      if ({j, k} == 2'b11) toggles++;
      check("t4_jk0", {30'd0, j, k}, 32'd3);
      tick();
      run = 1'b0;
      #1;
      if ({j, k} == 2'b11) toggles++;
      check("t4_jk1", {30'd0, j, k}, 32'd0);
      tick();
      check("t4_pause_busy", {31'd0, busy}, 32'd1);
      run = 1'b1;
      #1;
      if ({j, k} == 2'b11) toggles++;
      check("t4_jk2", {30'd0, j, k}, 32'd3);
      tick();
      if ({j, k} == 2'b11) toggles++;
      check("t4_jk3", {30'd0, j, k}, 32'd3);
      check("t4_done_early", {31'd0, done}, 32'd0);
      tick();
      check("t4_toggles", toggles, 32'd3);
      check("t4_end_jk", {30'd0, j, k}, 32'd0);
      check("t4_end_done", {31'd0, done}, 32'd1);
      // reset mid-ISSUE with two queued
      run = 1'b0;
      push(2'b11, 4'd5);
      push(2'b10, 4'd0);
      push(2'b01, 4'd0);
      run = 1'b1;
      tick();
      check("t5_issue_jk", {30'd0, j, k}, 32'd3);
      check("t5_issue_level", {29'd0, fifo_level}, 32'd2);
      rst = 1'b1;
      tick();
      check("t5_rst_jk", {30'd0, j, k}, 32'd0);
      check("t5_rst_level", {29'd0, fifo_level}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      tick();
      check("t5_idle_jk", {30'd0, j, k}, 32'd0);
      check("t5_idle_done", {31'd0, done}, 32'd0);
      check("t5_idle_busy", {31'd0, busy}, 32'd0);
`ifdef JKSEQ_SHADOW_EN
      push(2'b10, 4'd0);
      push(2'b11, 4'd1);
      push(2'b01, 4'd0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("sh_mismatch%0d", i), {31'd0, mismatch}, 32'd0);
         check($sformatf("sh_q%0d", i), {31'd0, q_shadow}, {31'd0, q_ff});
         tick();
      end
      check("sh_q_final", {31'd0, q_shadow}, 32'd0);
      inv = 1'b1;
      tick();
      inv = 1'b0;
      check("sh_set", {31'd0, mismatch}, 32'd1);
      tick(); tick();
      check("sh_sticky", {31'd0, mismatch}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("sh_clear", {31'd0, mismatch}, 32'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
